hazard_scoreboard: RTL

Parametrised pipeline hazard controller for the rv32imf core, sitting beside the decode stage. It generates load-use, branch-flush, structural and register-dependency (RAW/WAW) stall/flush controls for the core and for `NUM_UNITS` multicycle execution units (div, fsqrt, fdiv, …). Each unit is tracked with a registered busy/destination/age record. The block kills younger multicycle operations on a branch flush and flags units that exceed a cycle budget.

---
 rtl/hazard_scoreboard.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard controller: load-use, RAW/WAW, structural stalls and per-unit multicycle tracking.
// Optional perf counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_scoreboard #(
  parameter int NUM_UNITS = 3,
  parameter int REG_AW    = 6,
  parameter int TIMEOUT   = 64,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush_mem,
  input  logic                 id_valid,
  input  logic [REG_AW-1:0]    id_rs1,
  input  logic [REG_AW-1:0]    id_rs2,
  input  logic [REG_AW-1:0]    id_rs3,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic                 id_use_rs3,
  input  logic [REG_AW-1:0]    id_rd,
  input  logic                 id_wr_en,
  input  logic [NUM_UNITS-1:0] id_unit_req,
  input  logic                 exe_mem_read,
  input  logic [REG_AW-1:0]    exe_rd,
  input  logic [NUM_UNITS-1:0] unit_done,
  output logic                 stall_id,
  output logic                 flush_id,
  output logic                 load_hazard,
  output logic                 raw_hazard,
  output logic                 waw_hazard,
  output logic                 struct_hazard,
  output logic                 issue,
  output logic [NUM_UNITS-1:0] unit_busy,
  output logic [NUM_UNITS-1:0] unit_kill,
  output logic [NUM_UNITS-1:0] timeout_err,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     struct_cnt
);

  // state   | meaning
  // IDLE    | unit free, record fields are don't-care
  // BUSY    | unit executing; dest/wr valid, age and tcnt advancing
  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  localparam int TC_W = $clog2(TIMEOUT + 1);
  localparam logic [TC_W-1:0] TC_MAX = TC_W'(TIMEOUT);

  state_e            state_q [NUM_UNITS];
  state_e            state_d [NUM_UNITS];
  logic [REG_AW-1:0] dest_q  [NUM_UNITS];
  logic [REG_AW-1:0] dest_d  [NUM_UNITS];
  logic [1:0]        age_q   [NUM_UNITS];
  logic [1:0]        age_d   [NUM_UNITS];
  logic [TC_W-1:0]   tcnt_q  [NUM_UNITS];
  logic [TC_W-1:0]   tcnt_d  [NUM_UNITS];
  logic [NUM_UNITS-1:0] wr_q, wr_d, terr_q, terr_d;

  logic ld_raw, raw_raw, waw_raw, st_raw;

  function automatic logic src_hit(input logic [REG_AW-1:0] r);
    src_hit = (r != '0) &&
              ((id_use_rs1 && id_rs1 == r) ||
               (id_use_rs2 && id_rs2 == r) ||
               (id_use_rs3 && id_rs3 == r));
  endfunction

  always_comb begin
    ld_raw  = exe_mem_read && src_hit(exe_rd);
    raw_raw = 1'b0;
    waw_raw = 1'b0;
    st_raw  = 1'b0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (unit_busy[u] && wr_q[u]) begin
        raw_raw = raw_raw | src_hit(dest_q[u]);
        waw_raw = waw_raw | (id_wr_en && id_rd != '0 && id_rd == dest_q[u]);
      end
      st_raw = st_raw | (id_unit_req[u] && unit_busy[u]);
    end
  end

  assign load_hazard   = id_valid & ld_raw;
  assign raw_hazard    = id_valid & raw_raw;
  assign waw_hazard    = id_valid & waw_raw;
  assign struct_hazard = id_valid & st_raw;
  assign stall_id      = (load_hazard | raw_hazard | waw_hazard | struct_hazard) & ~flush_mem;
  assign issue         = id_valid & ~stall_id & ~flush_mem;
  assign flush_id      = flush_mem;
  assign timeout_err   = terr_q;

  // An op with age 0 entered the unit after the redirecting instruction, so it is on the wrong path.
  always_comb begin
    for (int u = 0; u < NUM_UNITS; u++) begin
      unit_busy[u] = (state_q[u] == ST_BUSY);
      unit_kill[u] = reset_n & flush_mem & unit_busy[u] & (age_q[u] == 2'd0);
    end
  end

  always_comb begin
    wr_d   = wr_q;
    terr_d = terr_q;
    for (int u = 0; u < NUM_UNITS; u++) begin
      state_d[u] = state_q[u];
      dest_d[u]  = dest_q[u];
      age_d[u]   = age_q[u];
      tcnt_d[u]  = tcnt_q[u];
      case (state_q[u])
        ST_IDLE: begin
          if (issue && id_unit_req[u]) begin
            state_d[u] = ST_BUSY;
            dest_d[u]  = id_rd;
            wr_d[u]    = id_wr_en && (id_rd != '0);
            age_d[u]   = 2'd0;
            tcnt_d[u]  = '0;
          end
        end
        ST_BUSY: begin
          age_d[u]  = (age_q[u] == 2'd3) ? 2'd3 : age_q[u] + 2'd1;
          tcnt_d[u] = (tcnt_q[u] == TC_MAX) ? TC_MAX : tcnt_q[u] + TC_W'(1);
          if (tcnt_d[u] == TC_MAX) terr_d[u] = 1'b1;
          if (unit_done[u] || unit_kill[u]) state_d[u] = ST_IDLE;
        end
        default: state_d[u] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q   <= '0;
      terr_q <= '0;
      for (int u = 0; u < NUM_UNITS; u++) begin
        state_q[u] <= ST_IDLE;
        dest_q[u]  <= '0;
        age_q[u]   <= '0;
        tcnt_q[u]  <= '0;
      end
    end else begin
      wr_q   <= wr_d;
      terr_q <= terr_d;
      for (int u = 0; u < NUM_UNITS; u++) begin
        state_q[u] <= state_d[u];
        dest_q[u]  <= dest_d[u];
        age_q[u]   <= age_d[u];
        tcnt_q[u]  <= tcnt_d[u];
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, struct_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt_q  <= '0;
      struct_cnt_q <= '0;
    end else begin
      if (stall_id)                   stall_cnt_q  <= stall_cnt_q + CNT_W'(1);
      if (struct_hazard && !flush_mem) struct_cnt_q <= struct_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign struct_cnt = struct_cnt_q;
`else
  assign stall_cnt  = '0;
  assign struct_cnt = '0;
`endif

endmodule
